// File: rtl/reset_sequencer.sv
// reset_sequencer: stretched power-on reset, staggered per-channel release,
// run-cycle counter with halt, and a sticky timeout that re-asserts all resets.
module reset_sequencer #(
  parameter int unsigned CHANNELS       = 2,
  parameter int unsigned HOLD_CYCLES    = 2,
  parameter int unsigned STAGGER_CYCLES = 3,
  parameter int unsigned RUN_LIMIT      = 500,
  parameter int unsigned COUNT_W        = 32
) (
  input  logic                clk,
  input  logic                r,
  input  logic                soft_rst_req,
  input  logic                halt_req,
  output logic [CHANNELS-1:0] rst_out,
  output logic                ready,
  output logic                timeout,
  output logic [COUNT_W-1:0]  cycle_count,
  output logic [1:0]          state
);

  localparam int unsigned HOLD_W    = (HOLD_CYCLES > 1)    ? $clog2(HOLD_CYCLES)    : 1;
  localparam int unsigned STAGGER_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
  localparam int unsigned IDX_W     = (CHANNELS > 1)       ? $clog2(CHANNELS)       : 1;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  state_e               state_q;
  logic [HOLD_W-1:0]    hold_cnt_q;
  logic [STAGGER_W-1:0] stagger_cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [CHANNELS-1:0]  rst_out_q;
  logic                 ready_q;
  logic                 timeout_q;
  logic [COUNT_W-1:0]   cycle_count_q;

  // Sequencer FSM: all outputs are registered here.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q       <= ST_HOLD;
      hold_cnt_q    <= '0;
      stagger_cnt_q <= '0;
      idx_q         <= '0;
      rst_out_q     <= '1;
      ready_q       <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_count_q <= '0;
    end else if (soft_rst_req) begin
      // Soft restart outranks every other event on this edge.
      state_q       <= ST_HOLD;
      hold_cnt_q    <= '0;
      stagger_cnt_q <= '0;
      idx_q         <= '0;
      rst_out_q     <= '1;
      ready_q       <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
            hold_cnt_q <= '0;
            // Release order is ascending, so shifting in a zero clears bit idx.
            rst_out_q  <= rst_out_q << 1;
            if (CHANNELS == 1) begin
              state_q <= ST_RUN;
              ready_q <= 1'b1;
            end else begin
              state_q       <= ST_RELEASE;
              idx_q         <= IDX_W'(1);
              stagger_cnt_q <= '0;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        ST_RELEASE: begin
          if (stagger_cnt_q == STAGGER_W'(STAGGER_CYCLES - 1)) begin
            stagger_cnt_q <= '0;
            rst_out_q     <= rst_out_q << 1;
            idx_q         <= idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(CHANNELS - 1)) begin
              state_q <= ST_RUN;
              ready_q <= 1'b1;
            end
          end else begin
            stagger_cnt_q <= stagger_cnt_q + STAGGER_W'(1);
          end
        end
        ST_RUN: begin
          if (!halt_req) begin
            if ((RUN_LIMIT != 0) && (cycle_count_q == COUNT_W'(RUN_LIMIT - 1))) begin
              cycle_count_q <= COUNT_W'(RUN_LIMIT);
              state_q       <= ST_TIMEOUT;
              timeout_q     <= 1'b1;
              ready_q       <= 1'b0;
              rst_out_q     <= '1;
            end else begin
              cycle_count_q <= cycle_count_q + COUNT_W'(1);
            end
          end
        end
        default: begin
          // Terminal timeout: everything holds until r or soft restart.
          state_q <= ST_TIMEOUT;
        end
      endcase
    end
  end

  assign rst_out     = rst_out_q;
  assign ready       = ready_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a 4-channel,
// no-timeout, narrow-counter instance for wrap behaviour.
module tb_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        r_a, soft_a, halt_a;
  logic [1:0]  rst_out_a;
  logic        ready_a, timeout_a;
  logic [31:0] count_a;
  logic [1:0]  state_a;

  // Four channels, fastest stagger, timeout disabled, 4-bit counter
  logic        r_b, soft_b, halt_b;
  logic [3:0]  rst_out_b;
  logic        ready_b, timeout_b;
  logic [3:0]  count_b;
  logic [1:0]  state_b;

  int checks   = 0;
  int failures = 0;

  // {state, rst_out, ready, timeout}
  wire [5:0] snap_a = {state_a, rst_out_a, ready_a, timeout_a};
  wire [7:0] snap_b = {state_b, rst_out_b, ready_b, timeout_b};

  localparam logic [5:0] S_RESET = 6'b00_11_0_0;
  localparam logic [5:0] S_REL0  = 6'b01_10_0_0;
  localparam logic [5:0] S_RUN   = 6'b10_00_1_0;
  localparam logic [5:0] S_TO    = 6'b11_11_0_1;

  reset_sequencer dut_a (
    .clk(clk), .r(r_a), .soft_rst_req(soft_a), .halt_req(halt_a),
    .rst_out(rst_out_a), .ready(ready_a), .timeout(timeout_a),
    .cycle_count(count_a), .state(state_a)
  );

  reset_sequencer #(
    .CHANNELS(4), .HOLD_CYCLES(1), .STAGGER_CYCLES(1), .RUN_LIMIT(0), .COUNT_W(4)
  ) dut_b (
    .clk(clk), .r(r_b), .soft_rst_req(soft_b), .halt_req(halt_b),
    .rst_out(rst_out_b), .ready(ready_b), .timeout(timeout_b),
    .cycle_count(count_b), .state(state_b)
  );

  // Advance n rising edges, then settle 1ns past the last one.
  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse r on dut_a, dropping it on a falling edge so the next rising edge is E1.
  task automatic release_a();
    @(negedge clk); r_a = 1'b1;
    @(negedge clk); r_a = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (snap_a !== S_RESET) begin failures++; $display("FAIL reset_snap got %b want %b", snap_a, S_RESET); end
    checks++;
    if (count_a !== 32'd0) begin failures++; $display("FAIL reset_count got %0d want 0", count_a); end
    #18 r_a = 1'b0;
    ticks(1);
    checks++;
    if (snap_a !== S_RESET) begin failures++; $display("FAIL e1_snap got %b want %b", snap_a, S_RESET); end
    ticks(1);
    checks++;
    if (snap_a !== S_REL0) begin failures++; $display("FAIL e2_snap got %b want %b", snap_a, S_REL0); end
    ticks(2);
    checks++;
    if (snap_a !== S_REL0) begin failures++; $display("FAIL e4_snap got %b want %b", snap_a, S_REL0); end
    ticks(1);
    checks++;
    if (snap_a !== S_RUN || count_a !== 32'd0) begin
      failures++; $display("FAIL e5_run got %b/%0d want %b/0", snap_a, count_a, S_RUN);
    end
    ticks(1);
    checks++;
    if (count_a !== 32'd1) begin failures++; $display("FAIL e6_count got %0d want 1", count_a); end
  endtask

  // Continues from E6 of test_reset.
  task automatic test_timeout();
    ticks(498);
    checks++;
    if (snap_a !== S_RUN || count_a !== 32'd499) begin
      failures++; $display("FAIL e504_run got %b/%0d want %b/499", snap_a, count_a, S_RUN);
    end
    ticks(1);
    checks++;
    if (snap_a !== S_TO || count_a !== 32'd500) begin
      failures++; $display("FAIL e505_timeout got %b/%0d want %b/500", snap_a, count_a, S_TO);
    end
    ticks(95);
    checks++;
    if (snap_a !== S_TO || count_a !== 32'd500) begin
      failures++; $display("FAIL e600_sticky got %b/%0d want %b/500", snap_a, count_a, S_TO);
    end
  endtask

  task automatic test_soft_rst();
    release_a();
    ticks(504);
    checks++;
    if (count_a !== 32'd499) begin failures++; $display("FAIL soft_pre_count got %0d want 499", count_a); end
    soft_a = 1'b1;
    ticks(1);
    soft_a = 1'b0;
    checks++;
    if (snap_a !== S_RESET || count_a !== 32'd0) begin
      failures++; $display("FAIL soft_at_limit got %b/%0d want %b/0", snap_a, count_a, S_RESET);
    end
    ticks(4);
    checks++;
    if (snap_a !== S_REL0) begin failures++; $display("FAIL soft_e4_snap got %b want %b", snap_a, S_REL0); end
    ticks(1);
    checks++;
    if (snap_a !== S_RUN) begin failures++; $display("FAIL soft_ready_snap got %b want %b", snap_a, S_RUN); end
    // Held high in RUN: stays in HOLD, then restarts on the first low edge.
    ticks(10);
    soft_a = 1'b1;
    ticks(4);
    checks++;
    if (snap_a !== S_RESET || count_a !== 32'd0) begin
      failures++; $display("FAIL soft_held got %b/%0d want %b/0", snap_a, count_a, S_RESET);
    end
    soft_a = 1'b0;
    ticks(1);
    checks++;
    if (snap_a !== S_RESET) begin failures++; $display("FAIL soft_held_e1 got %b want %b", snap_a, S_RESET); end
    ticks(1);
    checks++;
    if (snap_a !== S_REL0) begin failures++; $display("FAIL soft_held_e2 got %b want %b", snap_a, S_REL0); end
    ticks(3);
    checks++;
    if (snap_a !== S_RUN) begin failures++; $display("FAIL soft_held_e5 got %b want %b", snap_a, S_RUN); end
  endtask

  task automatic test_halt();
    release_a();
    ticks(100);
    checks++;
    if (count_a !== 32'd95) begin failures++; $display("FAIL halt_pre got %0d want 95", count_a); end
    halt_a = 1'b1;
    ticks(10);
    halt_a = 1'b0;
    checks++;
    if (count_a !== 32'd95) begin failures++; $display("FAIL halt_flat got %0d want 95", count_a); end
    ticks(1);
    checks++;
    if (count_a !== 32'd96) begin failures++; $display("FAIL halt_resume got %0d want 96", count_a); end
    ticks(403);
    checks++;
    if (snap_a !== S_RUN || count_a !== 32'd499) begin
      failures++; $display("FAIL halt_e514 got %b/%0d want %b/499", snap_a, count_a, S_RUN);
    end
    ticks(1);
    checks++;
    if (snap_a !== S_TO || count_a !== 32'd500) begin
      failures++; $display("FAIL halt_e515 got %b/%0d want %b/500", snap_a, count_a, S_TO);
    end
  endtask

  task automatic test_halt_at_limit();
    release_a();
    ticks(504);
    halt_a = 1'b1;
    ticks(3);
    halt_a = 1'b0;
    checks++;
    if (snap_a !== S_RUN || count_a !== 32'd499) begin
      failures++; $display("FAIL halt_limit_hold got %b/%0d want %b/499", snap_a, count_a, S_RUN);
    end
    ticks(1);
    checks++;
    if (snap_a !== S_TO || count_a !== 32'd500) begin
      failures++; $display("FAIL halt_limit_to got %b/%0d want %b/500", snap_a, count_a, S_TO);
    end
  endtask

  task automatic test_halt_outside_run();
    halt_a = 1'b1;
    release_a();
    ticks(5);
    checks++;
    if (snap_a !== S_RUN || count_a !== 32'd0) begin
      failures++; $display("FAIL halt_outside got %b/%0d want %b/0", snap_a, count_a, S_RUN);
    end
    halt_a = 1'b0;
    ticks(1);
    checks++;
    if (count_a !== 32'd1) begin failures++; $display("FAIL halt_outside_count got %0d want 1", count_a); end
  endtask

  task automatic test_async_reset();
    release_a();
    ticks(3);
    #2 r_a = 1'b1;
    #1;
    checks++;
    if (snap_a !== S_RESET) begin failures++; $display("FAIL async_snap got %b want %b", snap_a, S_RESET); end
    @(negedge clk); r_a = 1'b0;
    ticks(1);
    checks++;
    if (snap_a !== S_RESET) begin failures++; $display("FAIL async_e1 got %b want %b", snap_a, S_RESET); end
    ticks(1);
    checks++;
    if (snap_a !== S_REL0) begin failures++; $display("FAIL async_e2 got %b want %b", snap_a, S_REL0); end
    ticks(2);
    checks++;
    if (snap_a !== S_REL0) begin failures++; $display("FAIL async_e4 got %b want %b", snap_a, S_REL0); end
    ticks(1);
    checks++;
    if (snap_a !== S_RUN) begin failures++; $display("FAIL async_e5 got %b want %b", snap_a, S_RUN); end
  endtask

  task automatic test_wide_wrap();
    @(negedge clk); r_b = 1'b0;
    ticks(1);
    checks++;
    if (snap_b !== 8'b01_1110_0_0) begin failures++; $display("FAIL wide_e1 got %b want 01111000", snap_b); end
    ticks(1);
    checks++;
    if (snap_b !== 8'b01_1100_0_0) begin failures++; $display("FAIL wide_e2 got %b want 01110000", snap_b); end
    ticks(1);
    checks++;
    if (snap_b !== 8'b01_1000_0_0) begin failures++; $display("FAIL wide_e3 got %b want 01100000", snap_b); end
    ticks(1);
    checks++;
    if (snap_b !== 8'b10_0000_1_0) begin failures++; $display("FAIL wide_e4 got %b want 10000010", snap_b); end
    ticks(15);
    checks++;
    if (count_b !== 4'd15) begin failures++; $display("FAIL wide_e19_count got %0d want 15", count_b); end
    ticks(1);
    checks++;
    if (count_b !== 4'd0 || snap_b !== 8'b10_0000_1_0) begin
      failures++; $display("FAIL wide_wrap got %b/%0d want 10000010/0", snap_b, count_b);
    end
  endtask

  initial begin
    r_a = 1'b1; soft_a = 1'b0; halt_a = 1'b0;
    r_b = 1'b1; soft_b = 1'b0; halt_b = 1'b0;
    test_reset();
    test_timeout();
    test_soft_rst();
    test_halt();
    test_halt_at_limit();
    test_halt_outside_run();
    test_async_reset();
    test_wide_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
